// File: rtl/isqrt_share_arbiter.sv
// rtl/isqrt_share_arbiter.sv - round-robin sharing of one iterative isqrt unit among requesters
module isqrt_share_arbiter #(
    parameter int CHANNELS = 4,
    parameter int X_WIDTH  = 50,
    parameter int Y_WIDTH  = 25,
    parameter int TIMEOUT  = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         reqStrobe,
    input  logic [CHANNELS*X_WIDTH-1:0] reqOperand,
    output logic [X_WIDTH-1:0]          sqrtX,
    output logic                        sqrtEn,
    input  logic [Y_WIDTH-1:0]          sqrtY,
    input  logic                        sqrtDav,
    output logic [CHANNELS*Y_WIDTH-1:0] result,
    output logic [CHANNELS-1:0]         resultValid,
    output logic [CHANNELS-1:0]         overrun,
    input  logic                        overrunClear,
    output logic [15:0]                 timeoutCount,
    output logic                        busy
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW:0] CH_L = (CW+1)'(CHANNELS);
    localparam logic [CHANNELS-1:0] ONE = {{(CHANNELS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [X_WIDTH-1:0]  hold [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CW-1:0]       sel;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       next_ptr;
    logic [CW-1:0]       grant_idx;
    logic [CW:0]         cand;
    logic                grant_found;
    logic [CHANNELS-1:0] grant_clear;
    logic [15:0]         wait_cnt;

    // Scan downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = CHANNELS-1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(k);
            if (cand >= CH_L) cand = cand - CH_L;
            if (pending[cand[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CW-1:0];
            end
        end
    end

    assign grant_clear = (state == IDLE && grant_found) ? (ONE << grant_idx) : '0;
    assign next_ptr    = (sel == CW'(CHANNELS-1)) ? '0 : sel + 1'b1;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            sel          <= '0;
            rr_ptr       <= '0;
            wait_cnt     <= '0;
            sqrtX        <= '0;
            sqrtEn       <= 1'b0;
            result       <= '0;
            resultValid  <= '0;
            overrun      <= '0;
            timeoutCount <= '0;
        end else begin
            resultValid <= '0;
            sqrtEn      <= 1'b0;
            if (overrunClear) overrun <= '0;
            // A strobe landing on the grant cycle re-arms the channel without counting as overrun.
            for (int i = 0; i < CHANNELS; i++) begin
                if (reqStrobe[i]) begin
                    hold[i]    <= reqOperand[i*X_WIDTH +: X_WIDTH];
                    pending[i] <= 1'b1;
                    if (pending[i] && !grant_clear[i]) overrun[i] <= 1'b1;
                end else if (grant_clear[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sqrtX  <= hold[grant_idx];
                        sel    <= grant_idx;
                        sqrtEn <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (sqrtDav) begin
                        result[sel*Y_WIDTH +: Y_WIDTH] <= sqrtY;
                        resultValid <= ONE << sel;
                        rr_ptr      <= next_ptr;
                        state       <= IDLE;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        if (timeoutCount != 16'hFFFF) timeoutCount <= timeoutCount + 16'd1;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// tb/tb_isqrt_share_arbiter.sv - bench for isqrt_share_arbiter against an arithmetic isqrt model
module tb_isqrt_share_arbiter;
    localparam int CH = 4;
    localparam int XW = 50;
    localparam int YW = 25;
    localparam int TO = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    reqStrobe;
    logic [CH*XW-1:0] reqOperand;
    logic [XW-1:0]    sqrtX;
    logic             sqrtEn;
    logic [YW-1:0]    sqrtY;
    logic             sqrtDav;
    logic [CH*YW-1:0] result;
    logic [CH-1:0]    resultValid;
    logic [CH-1:0]    overrun;
    logic             overrunClear;
    logic [15:0]      timeoutCount;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 5;
    bit randLat = 0;
    int davCnt = 0;
    logic [XW-1:0] davOp;

    logic [XW-1:0] enX[$];
    int            enCyc[$];
    logic [CH-1:0] rvVec[$];
    int            rvCyc[$];
    logic [YW-1:0] rvVal[$];

    isqrt_share_arbiter #(.CHANNELS(CH), .X_WIDTH(XW), .Y_WIDTH(YW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .reqStrobe(reqStrobe), .reqOperand(reqOperand),
        .sqrtX(sqrtX), .sqrtEn(sqrtEn), .sqrtY(sqrtY), .sqrtDav(sqrtDav),
        .result(result), .resultValid(resultValid), .overrun(overrun),
        .overrunClear(overrunClear), .timeoutCount(timeoutCount), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned isq(input longint unsigned x);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 64'd1 << 25;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid; else hi = mid;
        end
        return lo;
    endfunction

    // One cycle: runs the isqrt model, logs sqrtEn and resultValid, then releases strobes.
    task automatic step();
        logic [YW-1:0] v;
        @(negedge clk);
        cyc++;
        sqrtDav = 1'b0;
        if (davCnt > 0) begin
            davCnt--;
            if (davCnt == 0) begin
                sqrtDav = 1'b1;
                sqrtY = YW'(isq(64'(davOp)));
            end
        end
        if (sqrtEn === 1'b1) begin
            enX.push_back(sqrtX);
            enCyc.push_back(cyc);
            davOp = sqrtX;
            if (randLat) davCnt = $urandom_range(1, 20);
            else if (lat > 0) davCnt = lat;
        end
        if (resultValid !== '0) begin
            v = '0;
            for (int k = CH-1; k >= 0; k--) if (resultValid[k]) v = result[k*YW +: YW];
            rvVec.push_back(resultValid);
            rvCyc.push_back(cyc);
            rvVal.push_back(v);
        end
        reqStrobe = '0;
    endtask

    task automatic post(input int ch, input logic [XW-1:0] v);
        reqStrobe[ch] = 1'b1;
        reqOperand[ch*XW +: XW] = v;
    endtask

    task automatic clear_logs();
        enX.delete(); enCyc.delete(); rvVec.delete(); rvCyc.delete(); rvVal.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        reqStrobe = '0;
        overrunClear = 1'b0;
        davCnt = 0;
        step();
        step();
        reset = 1'b0;
        lat = 5;
        randLat = 0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reqStrobe = '0;
        reqOperand = '0;
        overrunClear = 1'b0;
        sqrtY = '0;
        sqrtDav = 1'b0;
        step();
        step();
        checks++;
        if ({sqrtX, sqrtEn, result, resultValid, overrun, timeoutCount, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got sqrtX=%0h en=%b result=%0h rv=%b ovr=%b to=%0d busy=%b required all zero",
                     sqrtX, sqrtEn, result, resultValid, overrun, timeoutCount, busy);
        end
        reset = 1'b0;
        step();
        checks++;
        if (sqrtEn !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: got en=%b busy=%b required 0 0", sqrtEn, busy);
        end
        clear_logs();
    endtask

    task automatic test_single();
        int s;
        do_reset();
        lat = 30;
        step();
        post(2, 50'd10000);
        s = cyc;
        for (int k = 0; k < 45; k++) step();
        checks++;
        if (enX.size() !== 1 || enX[0] !== 50'd10000 || enCyc[0] !== s + 2) begin
            errors++;
            $display("FAIL single_issue: got %0d pulses first cycle offset %0d required 1 pulse at offset 2",
                     enX.size(), (enCyc.size() > 0) ? enCyc[0] - s : -1);
        end
        checks++;
        if (rvVec.size() !== 1 || rvVec[0] !== 4'b0100 || rvCyc[0] !== s + 33) begin
            errors++;
            $display("FAIL single_valid: got %0d pulses vec=%b offset=%0d required 1 pulse 0100 at offset 33",
                     rvVec.size(), (rvVec.size() > 0) ? rvVec[0] : 4'b0, (rvCyc.size() > 0) ? rvCyc[0] - s : -1);
        end
        checks++;
        if (result[2*YW +: YW] !== 25'd100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_result: got result2=%0d busy=%b required 100 0", result[2*YW +: YW], busy);
        end
    endtask

    task automatic test_all_four();
        do_reset();
        lat = 4;
        step();
        post(0, 50'd1); post(1, 50'd4); post(2, 50'd9); post(3, 50'd16);
        for (int k = 0; k < 60; k++) step();
        checks++;
        if (enX.size() !== 4 || rvVec.size() !== 4) begin
            errors++;
            $display("FAIL all4_count: got %0d issues %0d valids required 4 4", enX.size(), rvVec.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (enX[k] !== XW'((k+1)*(k+1)) || rvVec[k] !== CH'(1 << k) || rvVal[k] !== YW'(k+1)) begin
                    errors++;
                    $display("FAIL all4_order%0d: got x=%0d vec=%b y=%0d required x=%0d vec=%b y=%0d",
                             k, enX[k], rvVec[k], rvVal[k], (k+1)*(k+1), CH'(1 << k), k+1);
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (enCyc[k+1] - enCyc[k] !== lat + 2) begin
                    errors++;
                    $display("FAIL all4_gap%0d: got %0d cycles required %0d", k, enCyc[k+1] - enCyc[k], lat + 2);
                end
            end
        end
    endtask

    task automatic test_fairness();
        logic [XW-1:0] exp3 [5];
        logic [XW-1:0] cur0;
        int seen;
        int nxt;
        exp3 = '{50'd100, 50'd200, 50'd300, 50'd400, 50'd101};
        do_reset();
        lat = 3;
        step();
        post(0, 50'd100); post(1, 50'd200); post(2, 50'd300); post(3, 50'd400);
        cur0 = 50'd100;
        seen = 0;
        nxt = 101;
        for (int k = 0; k < 80; k++) begin
            step();
            if (enX.size() > seen) begin
                seen = enX.size();
                if (enX[seen-1] == cur0 && nxt < 104) begin
                    cur0 = XW'(nxt);
                    post(0, XW'(nxt));
                    nxt++;
                end
            end
        end
        checks++;
        if (enX.size() < 5) begin
            errors++;
            $display("FAIL fair_count: got %0d grants required at least 5", enX.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (enX[k] !== exp3[k]) begin
                    errors++;
                    $display("FAIL fair_order%0d: got %0d required %0d", k, enX[k], exp3[k]);
                end
            end
        end
        checks++;
        if (overrun !== '0) begin
            errors++;
            $display("FAIL fair_overrun: got %b required 0000", overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        lat = 10;
        step();
        post(0, 50'd7);
        step(); step(); step();
        post(1, 50'd25);
        step();
        post(1, 50'd49);
        step();
        checks++;
        if (overrun !== 4'b0010) begin
            errors++;
            $display("FAIL ovr_set: got %b required 0010", overrun);
        end
        for (int k = 0; k < 40; k++) step();
        checks++;
        if (enX.size() !== 2 || enX[1] !== 50'd49 || result[1*YW +: YW] !== 25'd7) begin
            errors++;
            $display("FAIL ovr_latest: got %0d issues result1=%0d required 2 issues result1=7",
                     enX.size(), result[1*YW +: YW]);
        end
        overrunClear = 1'b1;
        step();
        overrunClear = 1'b0;
        checks++;
        if (overrun !== '0) begin
            errors++;
            $display("FAIL ovr_clear: got %b required 0000", overrun);
        end
        post(0, 50'd5);
        step(); step(); step();
        post(2, 50'd1);
        step();
        post(2, 50'd4);
        overrunClear = 1'b1;
        step();
        overrunClear = 1'b0;
        checks++;
        if (overrun !== 4'b0100) begin
            errors++;
            $display("FAIL ovr_set_wins: got %b required 0100", overrun);
        end
        for (int k = 0; k < 40; k++) step();
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        lat = 0;
        step();
        post(0, 50'd64); post(1, 50'd81);
        for (int k = 0; k < 10 && enX.size() == 0; k++) step();
        checks++;
        if (enX.size() == 0) begin
            errors++;
            $display("FAIL to_issue: got no sqrtEn required one within 10 cycles");
            return;
        end
        c = enCyc[0];
        lat = 3;
        while (cyc < c + TO) step();
        checks++;
        if (busy !== 1'b1 || timeoutCount !== 16'd0) begin
            errors++;
            $display("FAIL to_last_wait: got busy=%b count=%0d required 1 0", busy, timeoutCount);
        end
        step();
        checks++;
        if (busy !== 1'b0 || timeoutCount !== 16'd1 || rvVec.size() !== 0) begin
            errors++;
            $display("FAIL to_expire: got busy=%b count=%0d valids=%0d required 0 1 0", busy, timeoutCount, rvVec.size());
        end
        for (int k = 0; k < 20; k++) step();
        checks++;
        if (enX.size() !== 2 || enX[1] !== 50'd81 || enCyc[1] !== c + TO + 2) begin
            errors++;
            $display("FAIL to_next: got %0d issues, second offset %0d required 2 issues second x=81 at offset %0d",
                     enX.size(), (enCyc.size() > 1) ? enCyc[1] - c : -1, TO + 2);
        end
        checks++;
        if (rvVec.size() !== 1 || rvVec[0] !== 4'b0010 || rvVal[0] !== 25'd9 || result[YW-1:0] !== '0) begin
            errors++;
            $display("FAIL to_result: got %0d valids result0=%0d required one 0010 with y=9 and result0=0",
                     rvVec.size(), result[YW-1:0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        lat = 0;
        step();
        post(0, 50'd36);
        step();
        post(3, 50'd100);
        step(); step(); step(); step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy: got %b required 1", busy);
        end
        reset = 1'b1;
        davCnt = 2;
        davOp = 50'd36;
        clear_logs();
        step();
        reset = 1'b0;
        for (int k = 0; k < 15; k++) step();
        checks++;
        if (rvVec.size() !== 0 || enX.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: got valids=%0d issues=%0d busy=%b required 0 0 0", rvVec.size(), enX.size(), busy);
        end
        checks++;
        if (result !== '0 || timeoutCount !== 16'd0) begin
            errors++;
            $display("FAIL rst_state: got result=%0h count=%0d required 0 0", result, timeoutCount);
        end
    endtask

    task automatic test_random();
        bit            mpend [CH];
        logic [XW-1:0] mop [CH];
        int            mcyc [CH];
        int            mrr;
        int            ne;
        int            nr;
        int            g;
        int            expCh[$];
        logic [XW-1:0] expOp[$];
        logic [XW-1:0] v;
        do_reset();
        randLat = 1;
        for (int i = 0; i < CH; i++) begin mpend[i] = 0; mop[i] = '0; mcyc[i] = 0; end
        mrr = 0; ne = 0; nr = 0;
        for (int t = 0; t < 3000; t++) begin
            step();
            while (nr < rvVec.size()) begin
                checks++;
                if (expCh.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_unexpected_valid: got vec=%b required none", rvVec[nr]);
                end else begin
                    g = expCh.pop_front();
                    v = expOp.pop_front();
                    if (rvVec[nr] !== CH'(1 << g) || rvVal[nr] !== YW'(isq(64'(v)))) begin
                        errors++;
                        $display("FAIL rnd_result: got vec=%b y=%0d required vec=%b y=%0d",
                                 rvVec[nr], rvVal[nr], CH'(1 << g), isq(64'(v)));
                    end
                    mrr = (g + 1) % CH;
                end
                nr++;
            end
            while (ne < enX.size()) begin
                g = -1;
                for (int k = CH-1; k >= 0; k--) begin
                    if (mpend[(mrr + k) % CH] && mcyc[(mrr + k) % CH] <= enCyc[ne] - 2) g = (mrr + k) % CH;
                end
                checks++;
                if (g < 0) begin
                    errors++;
                    $display("FAIL rnd_grant: got issue x=%0d required no issue", enX[ne]);
                end else begin
                    if (enX[ne] !== mop[g]) begin
                        errors++;
                        $display("FAIL rnd_grant: got x=%0d required ch%0d x=%0d", enX[ne], g, mop[g]);
                    end
                    mpend[g] = 0;
                    expCh.push_back(g);
                    expOp.push_back(mop[g]);
                end
                ne++;
            end
            if (t < 2800) begin
                for (int i = 0; i < CH; i++) begin
                    if (!mpend[i] && $urandom_range(0, 7) == 0) begin
                        case ($urandom_range(0, 9))
                            0: v = '0;
                            1: v = '1;
                            default: v = XW'({$urandom(), $urandom()});
                        endcase
                        post(i, v);
                        mpend[i] = 1;
                        mop[i] = v;
                        mcyc[i] = cyc;
                    end
                end
            end
        end
        checks++;
        if (expCh.size() !== 0 || mpend[0] || mpend[1] || mpend[2] || mpend[3] || nr < 20) begin
            errors++;
            $display("FAIL rnd_drain: got outstanding=%0d served=%0d required 0 outstanding and at least 20 served",
                     expCh.size(), nr);
        end
        checks++;
        if (overrun !== '0 || timeoutCount !== 16'd0) begin
            errors++;
            $display("FAIL rnd_flags: got overrun=%b count=%0d required 0000 0", overrun, timeoutCount);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_overrun();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
